pipe_shifter: RTL and testbench

PIPE_SHIFTER -- requirements
Module: pipe_shifter

---
 rtl/pipe_shifter_pkg.sv | 23 ++
 rtl/pipe_shifter_if.sv | 32 +++
 rtl/pipe_shifter_shift_stage.sv | 85 ++++++++
 rtl/pipe_shifter.sv | 126 ++++++++++++
 tb/tb_pipe_shifter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_shifter_pkg.sv
// pipe_shifter_pkg
//   Shared definitions for the pipelined barrel shifter: operation encodings
//   and a constant log2 helper used to size the shift-amount and stage count.
package pipe_shifter_pkg;

  typedef enum logic [1:0] {
    OP_LSL = 2'b00,  // logical
    OP_ASR = 2'b01,  // arithmetic (sign fill on right shifts)
    OP_ROT = 2'b10,  // rotate
    OP_RSV = 2'b11   // reserved, behaves as logical
  } op_e;

  // Ceiling log2; exact for the power-of-two widths this block supports.
  function automatic int log2_f(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_shifter_if.sv
// pipe_shifter_if
//   Request/result handshake bundle for pipe_shifter.
//   master : producer/consumer side (drives in_valid, ain, bin, op, out_ready)
//   slave  : the shifter (drives in_ready, out_valid, yout, zero)
interface pipe_shifter_if #(
  parameter int WIDTH = 16
);
  import pipe_shifter_pkg::*;

  localparam int SW = log2_f(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] ain;
  logic [SW:0]      bin;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] yout;
  logic             zero;

  modport master (
    output in_valid, ain, bin, op, out_ready,
    input  in_ready, out_valid, yout, zero
  );

  modport slave (
    input  in_valid, ain, bin, op, out_ready,
    output in_ready, out_valid, yout, zero
  );

endinterface

// File: rtl/pipe_shifter_shift_stage.sv
// shift_stage
//   One registered pipeline stage of the barrel shifter: shifts the operand
//   left by 2^K when magnitude bit K is set. Vacated bits take the fill bit,
//   or the bits shifted out when the op is rotate. Right shifts arrive here
//   already bit-reversed, so only a left shifter is needed.
//   Ports:
//     clk, rst_n        clock, async active-low reset
//     i_en              global pipeline advance
//     i_valid/o_valid   stage valid
//     i_data/o_data     operand
//     i_mag/o_mag       shift magnitude (carried to later stages)
//     i_fill/o_fill     fill bit for vacated positions
//     i_dir/o_dir       1 = right shift (data is bit-reversed)
//     i_op/o_op         operation
module shift_stage
  import pipe_shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int K     = 0,
  parameter int MW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic [MW-1:0]    i_mag,
  input  logic             i_fill,
  input  logic             i_dir,
  input  op_e              i_op,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [MW-1:0]    o_mag,
  output logic             o_fill,
  output logic             o_dir,
  output op_e              o_op
);

  localparam int SH = 1 << K;

  logic [WIDTH-1:0] w_shifted;

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [MW-1:0]    r_mag;
  logic             r_fill;
  logic             r_dir;
  op_e              r_op;

  always_comb begin
    w_shifted = i_data;
    if (i_mag[K]) begin
      if (i_op == OP_ROT)
        w_shifted = {i_data[WIDTH-SH-1:0], i_data[WIDTH-1:WIDTH-SH]};
      else
        w_shifted = {i_data[WIDTH-SH-1:0], {SH{i_fill}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_mag   <= '0;
      r_fill  <= 1'b0;
      r_dir   <= 1'b0;
      r_op    <= OP_LSL;
    end else if (i_en) begin
      r_valid <= i_valid;
      r_data  <= w_shifted;
      r_mag   <= i_mag;
      r_fill  <= i_fill;
      r_dir   <= i_dir;
      r_op    <= i_op;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_mag   = r_mag;
  assign o_fill  = r_fill;
  assign o_dir   = r_dir;
  assign o_op    = r_op;

endmodule

// File: rtl/pipe_shifter.sv
// pipe_shifter
//   Pipelined logical/arithmetic/rotate barrel shifter with a valid/ready
//   handshake. A decode register captures |bin|, direction, fill bit and op,
//   then SW shift stages (2^(SW-1) down to 1) complete the shift. Latency is
//   SW+1 enabled cycles; the whole pipe advances or holds as one unit.
//   Ports:
//     clk    clock
//     rst_n  async active-low reset
//     bus    pipe_shifter_if.slave (in_valid/in_ready, ain, bin, op,
//            out_valid/out_ready, yout, zero)
module pipe_shifter
  import pipe_shifter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic           clk,
  input logic           rst_n,
  pipe_shifter_if.slave bus
);

  localparam int SW = log2_f(WIDTH);
  localparam int MW = SW + 1;
  localparam logic [MW-1:0] MAG_ONE = {{SW{1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
    return r;
  endfunction

  logic             w_en;
  logic             w_dir;
  logic [MW-1:0]    w_mag;
  op_e              w_op;
  logic             w_fill;
  logic [WIDTH-1:0] w_dec_data;

  logic             r_dec_valid;
  logic [WIDTH-1:0] r_dec_data;
  logic [MW-1:0]    r_dec_mag;
  logic             r_dec_fill;
  logic             r_dec_dir;
  op_e              r_dec_op;

  // Index 0 is the decode register, index i+1 the output of stage i.
  logic             w_valid [0:SW];
  logic [WIDTH-1:0] w_data  [0:SW];
  logic [MW-1:0]    w_mag_s [0:SW];
  logic             w_fill_s[0:SW];
  logic             w_dir_s [0:SW];
  op_e              w_op_s  [0:SW];

  logic [WIDTH-1:0] w_result;

  assign w_en = !bus.out_valid || bus.out_ready;

  always_comb begin
    w_dir  = bus.bin[SW];
    w_mag  = w_dir ? (~bus.bin + MAG_ONE) : bus.bin;
    w_op   = op_e'(bus.op);
    w_fill = (w_op == OP_ASR) && w_dir && bus.ain[WIDTH-1];
    w_dec_data = w_dir ? bit_rev(bus.ain) : bus.ain;
    // A shift by the full width only occurs for bin = -WIDTH, where the low
    // magnitude bits are zero; resolve it here so the stages never see it.
    if (w_mag[SW] && (w_op != OP_ROT))
      w_dec_data = {WIDTH{w_fill}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec_valid <= 1'b0;
      r_dec_data  <= '0;
      r_dec_mag   <= '0;
      r_dec_fill  <= 1'b0;
      r_dec_dir   <= 1'b0;
      r_dec_op    <= OP_LSL;
    end else if (w_en) begin
      r_dec_valid <= bus.in_valid;
      r_dec_data  <= w_dec_data;
      r_dec_mag   <= w_mag;
      r_dec_fill  <= w_fill;
      r_dec_dir   <= w_dir;
      r_dec_op    <= w_op;
    end
  end

  assign w_valid[0]  = r_dec_valid;
  assign w_data[0]   = r_dec_data;
  assign w_mag_s[0]  = r_dec_mag;
  assign w_fill_s[0] = r_dec_fill;
  assign w_dir_s[0]  = r_dec_dir;
  assign w_op_s[0]   = r_dec_op;

  for (genvar i = 0; i < SW; i++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .K     (SW - 1 - i),
      .MW    (MW)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_en),
      .i_valid (w_valid[i]),
      .i_data  (w_data[i]),
      .i_mag   (w_mag_s[i]),
      .i_fill  (w_fill_s[i]),
      .i_dir   (w_dir_s[i]),
      .i_op    (w_op_s[i]),
      .o_valid (w_valid[i+1]),
      .o_data  (w_data[i+1]),
      .o_mag   (w_mag_s[i+1]),
      .o_fill  (w_fill_s[i+1]),
      .o_dir   (w_dir_s[i+1]),
      .o_op    (w_op_s[i+1])
    );
  end

  assign w_result = w_dir_s[SW] ? bit_rev(w_data[SW]) : w_data[SW];

  assign bus.in_ready  = w_en;
  assign bus.out_valid = w_valid[SW];
  // Gated so stale datapath contents never appear on the output.
  assign bus.yout      = w_valid[SW] ? w_result : '0;
  assign bus.zero      = w_valid[SW] && (w_result == '0);

endmodule

// File: tb/tb_pipe_shifter.sv
module tb_pipe_shifter;
  import pipe_shifter_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_shifter_if #(.WIDTH(W)) bus ();
  pipe_shifter #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [15:0] ain;
    logic [4:0]  bin;
    logic [1:0]  op;
    logic [15:0] exp_y;
    logic        exp_z;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  int errors = 0;
  int checks = 0;
  int delivered = 0;
  int accepted = 0;
  int stalls = 0;
  logic [15:0] exp_q [$];
  logic        stall_prev = 1'b0;
  logic [15:0] stall_y;
  logic        stall_z;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rotl(input logic [15:0] a, input int k);
    logic [31:0] t;
    int m;
    m = k % 16;
    if (m == 0) return a;
    t = ({16'h0, a} << m) | ({16'h0, a} >> (16 - m));
    return t[15:0];
  endfunction

  // Reference: signed amount, left if non-negative, right by |amount| otherwise.
  function automatic logic [15:0] model(input logic [15:0] a, input logic [4:0] b, input logic [1:0] op);
    int amt;
    int s;
    logic [31:0] t;
    amt = int'($signed(b));
    if (op == 2'b10) return (amt >= 0) ? rotl(a, amt) : rotl(a, 16 - ((-amt) % 16));
    if (amt >= 0) begin
      t = {16'h0, a} << amt;
      return t[15:0];
    end
    if (op == 2'b01) begin
      s = int'($signed(a));
      s = s >>> (-amt);
      return 16'(s);
    end
    t = {16'h0, a} >> (-amt);
    return t[15:0];
  endfunction

  // Inputs are already set for the coming edge; book-keep, then cross it.
  task automatic step();
    logic [15:0] e;
    #1;
    chk("in_ready_rule", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
    if (stall_prev) begin
      chk("stall_valid", 32'(bus.out_valid), 32'(1));
      chk("stall_yout", 32'(bus.yout), 32'(stall_y));
      chk("stall_zero", 32'(bus.zero), 32'(stall_z));
    end
    if (!bus.out_valid) chk("idle_gated", {15'h0, bus.zero, bus.yout}, 32'(0));
    stall_prev = bus.out_valid && !bus.out_ready;
    stall_y = bus.yout;
    stall_z = bus.zero;
    if (stall_prev) stalls++;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h expected none", bus.yout);
      end else begin
        e = exp_q.pop_front();
        chk("result", 32'(bus.yout), 32'(e));
        chk("zero", 32'(bus.zero), 32'(e == 16'h0));
        delivered++;
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      exp_q.push_back(model(bus.ain, bus.bin, bus.op));
      accepted++;
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, a0, d0, s0, oc;
    logic seen;

    vecs[0]  = '{16'h8001, 5'h01, 2'b00, 16'h0002, 1'b0};
    vecs[1]  = '{16'h8000, 5'h1C, 2'b01, 16'hF800, 1'b0};
    vecs[2]  = '{16'h8000, 5'h1C, 2'b00, 16'h0800, 1'b0};
    vecs[3]  = '{16'h8000, 5'h1C, 2'b11, 16'h0800, 1'b0};
    vecs[4]  = '{16'h0001, 5'h1F, 2'b10, 16'h8000, 1'b0};
    vecs[5]  = '{16'h0001, 5'h10, 2'b10, 16'h0001, 1'b0};
    vecs[6]  = '{16'h0001, 5'h10, 2'b00, 16'h0000, 1'b1};
    vecs[7]  = '{16'h8000, 5'h10, 2'b01, 16'hFFFF, 1'b0};
    vecs[8]  = '{16'hA5C3, 5'h00, 2'b10, 16'hA5C3, 1'b0};
    vecs[9]  = '{16'hA5C3, 5'h00, 2'b01, 16'hA5C3, 1'b0};
    vecs[10] = '{16'h1234, 5'h04, 2'b10, 16'h2341, 1'b0};
    vecs[11] = '{16'h8001, 5'h0F, 2'b01, 16'h8000, 1'b0};
    vecs[12] = '{16'h1234, 5'h18, 2'b10, 16'h3412, 1'b0};
    vecs[13] = '{16'h7000, 5'h1D, 2'b01, 16'h0E00, 1'b0};

    bus.in_valid = 1'b0;
    bus.ain = '0;
    bus.bin = '0;
    bus.op = 2'b00;
    bus.out_ready = 1'b0;

    // Reset state, asserted from time zero.
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_yout", 32'(bus.yout), 32'(0));
    chk("rst_zero", 32'(bus.zero), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'(1));

    // Directed vectors, one at a time: value, zero flag and latency.
    for (int i = 0; i < NV; i++) begin
      bus.ain = vecs[i].ain;
      bus.bin = vecs[i].bin;
      bus.op = vecs[i].op;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      step();
      bus.in_valid = 1'b0;
      n = 1;
      while (!bus.out_valid && n < 20) begin
        step();
        n++;
      end
      chk($sformatf("vec%0d_latency", i), 32'(n), 32'(5));
      chk($sformatf("vec%0d_yout", i), 32'(bus.yout), 32'(vecs[i].exp_y));
      chk($sformatf("vec%0d_zero", i), 32'(bus.zero), 32'(vecs[i].exp_z));
      step();
    end

    // Backpressure: 8 back-to-back requests, consumer stalls for 4 cycles
    // starting on the 4th cycle that a result is presented.
    a0 = accepted;
    d0 = delivered;
    s0 = stalls;
    seen = 1'b0;
    oc = 0;
    for (int c = 0; c < 60 && ((accepted - a0) < 8 || exp_q.size() > 0); c++) begin
      if (!seen && bus.out_valid) seen = 1'b1;
      bus.in_valid = ((accepted - a0) < 8);
      bus.ain = 16'($urandom);
      bus.bin = 5'($urandom);
      bus.op = 2'($urandom);
      bus.out_ready = !(seen && oc >= 3 && oc <= 6);
      step();
      if (seen) oc++;
    end
    chk("bp_accepted", 32'(accepted - a0), 32'(8));
    chk("bp_delivered", 32'(delivered - d0), 32'(8));
    chk("bp_stall_cycles", 32'(stalls - s0), 32'(4));
    chk("bp_queue_empty", 32'(exp_q.size()), 32'(0));

    // Reset mid-stream with several requests in flight.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.ain = 16'($urandom);
      bus.bin = 5'($urandom);
      bus.op = 2'($urandom);
      step();
    end
    bus.in_valid = 1'b0;
    chk("midrst_pre_valid", 32'(bus.out_valid), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("midrst_yout", 32'(bus.yout), 32'(0));
    chk("midrst_zero", 32'(bus.zero), 32'(0));
    #1 rst_n = 1'b1;
    exp_q.delete();
    stall_prev = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'(1));
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("midrst_no_stale", 32'(bus.out_valid), 32'(0));
    end

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      bus.in_valid = ($urandom_range(9) < 7);
      bus.out_ready = ($urandom_range(9) < 6);
      bus.ain = 16'($urandom);
      bus.bin = 5'($urandom);
      bus.op = 2'($urandom);
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) step();
    chk("drain_queue_empty", 32'(exp_q.size()), 32'(0));
    chk("drain_out_valid", 32'(bus.out_valid), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
